// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter for the host link. Bytes arrive from the coprocessor
// result logic over a valid/ready write port. They are held in a small FIFO
// and sent as 8N1 frames (start bit, 8 data bits LSB first, stop bit) on the
// tx line. Bit timing is generated internally from the system clock, so no
// external baud tick is needed.
//
// Handshake: a byte on tx_data is accepted on a rising clk edge when
// tx_valid & tx_ready are both 1. tx_ready depends only on registered state
// (FIFO not full). tx_valid must not depend combinationally on tx_ready. If
// tx_valid is high while tx_ready is low, the byte is dropped and
// tx_overflow is high for that cycle.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous active-low reset (0 = in reset)
//   tx_data      byte to transmit
//   tx_valid     write request
//   tx_ready     FIFO not full
//   tx           serial line, registered, idle high
//   tx_busy      a frame is in progress or the FIFO holds bytes
//   tx_overflow  write attempted while full (byte dropped)
//   dbg_state    current transmit state (debug / checker visibility)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic [1:0] dbg_state
);

  localparam int BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam int CYC_W      = $clog2(BIT_CYCLES);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_e           state_q,  state_d;
  logic [CYC_W-1:0] cyc_q,    cyc_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,  shift_d;
  logic             tx_q,     tx_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push;
  logic pop;
  logic bit_done;
  logic fifo_nonempty;

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  // Readiness comes from the registered count only: a pop in the same cycle
  // does not make room for a push, so a write to a full FIFO is always
  // rejected.
  assign tx_ready      = (count_q != CNT_FULL);
  assign push          = tx_valid & tx_ready;
  assign tx_overflow   = tx_valid & ~tx_ready;
  assign fifo_nonempty = (count_q != '0);

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = tx_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Transmit state machine
  // -------------------------------------------------------------------------
  // cyc_q counts the clocks within the current bit; the last clock of a bit
  // is where the next line value is loaded, so each bit is held exactly
  // BIT_CYCLES clocks.
  assign bit_done = (cyc_q == CYC_LAST);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cyc_d     = '0;
        bit_idx_d = '0;
        tx_d      = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (bit_done) begin
          cyc_d     = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = ST_DATA;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          cyc_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            // The bit now on the line is shift_q[0]; the next one is bit 1.
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_done) begin
          cyc_d = '0;
          if (fifo_nonempty) begin
            // Start the next frame straight from the stop bit: no idle gap.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      default: begin
        cyc_d   = '0;
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential state. Reset drops any frame in flight and all queued bytes;
  // tx returns high as soon as reset asserts.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign tx        = tx_q;
  assign tx_busy   = (state_q != ST_IDLE) | fifo_nonempty;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Bench for uart_tx_fifo with BIT_CYCLES = 16 and a 4-entry FIFO.
// The reference model is a byte queue plus a "frame in flight" record
// (start edge, byte); expected tx is derived from the frame's elapsed
// time. A separate line decoder recovers bytes from tx and compares them
// with the bytes the model accepted.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CLK_FREQUENCY = 1_600_000;
  localparam int BAUD_RATE     = 100_000;
  localparam int BIT_CYCLES    = 16;
  localparam int FIFO_DEPTH    = 4;
  localparam int FRAME         = 10 * BIT_CYCLES;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_overflow;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQUENCY (CLK_FREQUENCY),
    .BAUD_RATE     (BAUD_RATE),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_overflow (tx_overflow),
    .dbg_state   (dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq[$];        // bytes waiting in the FIFO
  logic [7:0] exp_q[$];     // bytes expected on the line, in order
  bit         m_active = 1'b0;
  int         m_start = 0;  // edge at which current frame's start bit began
  logic [7:0] m_byte = 8'h00;
  int         edge_n = 0;

  // samples taken at the falling edge
  logic s_tx, s_ready, s_busy, s_ovf;
  int   s_edge;

  function automatic logic model_tx();
    int e;
    int b;
    if (!m_active) return 1'b1;
    e = edge_n - m_start;
    b = e / BIT_CYCLES;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  // Advance the model across the coming rising edge.
  task automatic model_advance();
    int  m;
    bit  acc;
    m   = edge_n + 1;
    acc = tx_valid && (mq.size() < FIFO_DEPTH);
    if (reset) begin
      if (m_active && (m == m_start + FRAME)) m_active = 1'b0;
      if (!m_active && (mq.size() > 0)) begin
        m_byte   = mq.pop_front();
        m_active = 1'b1;
        m_start  = m;
      end
      if (acc) begin
        mq.push_back(tx_data);
        exp_q.push_back(tx_data);
      end
    end
  endtask

  // One clock: sample and compare at the falling edge, advance the model,
  // then step past the rising edge.
  task automatic step_cycle();
    @(negedge clk);
    s_tx    = tx;
    s_ready = tx_ready;
    s_busy  = tx_busy;
    s_ovf   = tx_overflow;
    s_edge  = edge_n;
    check("ready", s_ready, mq.size() < FIFO_DEPTH);
    check("overflow", s_ovf, tx_valid && (mq.size() >= FIFO_DEPTH));
    check("busy", s_busy, m_active || (mq.size() > 0));
    check("tx", s_tx, model_tx());
    model_advance();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((m_active || mq.size() > 0 || s_busy) && i < budget) begin
      step_cycle();
      i++;
    end
    check("drain_in_time", i < budget, 1);
    repeat (4) step_cycle();
  endtask

  // ---------------- line decoder ----------------
  bit         rx_active = 1'b0;
  int         rx_k = 0;
  logic [7:0] rx_byte = 8'h00;
  int         frames_seen = 0;

  always @(negedge clk) begin
    int idx;
    logic [8:0] want;
    if (!reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_k = 0;
      end
    end else begin
      rx_k++;
      if (rx_k == BIT_CYCLES / 2) begin
        check("rx_start_bit", tx, 0);
      end else if (rx_k == BIT_CYCLES / 2 + 9 * BIT_CYCLES) begin
        check("rx_stop_bit", tx, 1);
        frames_seen++;
        if (exp_q.size() > 0) want = {1'b0, exp_q.pop_front()};
        else want = 9'h100;
        check("rx_byte", {1'b0, rx_byte}, want);
        rx_active = 1'b0;
      end else if (((rx_k - BIT_CYCLES / 2) % BIT_CYCLES) == 0) begin
        idx = (rx_k - BIT_CYCLES / 2) / BIT_CYCLES - 1;
        rx_byte[idx[2:0]] = tx;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] b2b_bytes [3] = '{8'h00, 8'hFF, 8'h55};
  logic [7:0] rst_bytes [3] = '{8'hC3, 8'h3C, 8'h81};

  initial begin
    int bad_cnt;
    int busy_cnt;
    int fall_e;
    int end_e;
    int ovf_cnt;
    int frames_before;
    logic line_exp;

    // reset state
    #1 reset = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_overflow", tx_overflow, 0);
    repeat (3) step_cycle();
    reset = 1'b1;

    // idle line
    bad_cnt = 0;
    repeat (1000) begin
      step_cycle();
      if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_ovf !== 1'b0) bad_cnt++;
    end
    check("idle_line", bad_cnt, 0);

    // single byte 0xA5
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    step_cycle();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    bad_cnt  = 0;
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step_cycle();
      if (i == 0) line_exp = 1'b1;
      else if (i <= 16) line_exp = 1'b0;
      else if (i <= 144) line_exp = a5_bits[(i - 17) / 16];
      else line_exp = 1'b1;
      if (s_tx !== line_exp) bad_cnt++;
      if (i == 0) check("a5_before_fall", s_tx, 1);
      if (i == 1) check("a5_fall_latency", s_tx, 0);
      if (s_busy) busy_cnt++;
    end
    check("a5_line_bad_samples", bad_cnt, 0);
    check("a5_busy_cycles", busy_cnt, 161);
    check("a5_busy_end", s_busy, 0);

    // back-to-back 0x00 0xFF 0x55
    fall_e = -1;
    end_e  = -1;
    for (int i = 0; i < 703; i++) begin
      if (i < 3) begin
        tx_valid = 1'b1;
        tx_data  = b2b_bytes[i];
      end else begin
        tx_valid = 1'b0;
      end
      step_cycle();
      if (fall_e < 0 && s_tx === 1'b0) fall_e = s_edge;
      if (fall_e >= 0 && s_busy === 1'b0) begin
        end_e = s_edge;
        break;
      end
    end
    check("b2b_span", end_e - fall_e, 3 * FRAME);
    drain(1000);

    // full / overflow, then push while full in the STOP pop cycle
    ovf_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'h10 + 8'(i);
      step_cycle();
      check("full_ready", s_ready, i < 5);
      check("full_ovf", s_ovf, i == 5);
      if (s_ovf) ovf_cnt++;
    end
    tx_valid = 1'b0;
    step_cycle();
    if (s_ovf) ovf_cnt++;
    check("full_ovf_pulses", ovf_cnt, 1);
    repeat (154) step_cycle();
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    step_cycle();
    check("pwf_ready", s_ready, 0);
    check("pwf_ovf", s_ovf, 1);
    tx_valid = 1'b0;
    step_cycle();
    check("pwf_ready_after_pop", s_ready, 1);
    check("pwf_ovf_after", s_ovf, 0);
    check("pwf_next_start", s_tx, 0);
    drain(1200);

    // randomized traffic
    repeat (3000) begin
      tx_valid = ($urandom_range(0, 99) < 4);
      tx_data  = 8'($urandom);
      step_cycle();
    end
    tx_valid = 1'b0;
    drain(1200);

    // reset during data bit 3 of 0xC3 with two bytes queued
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1;
      tx_data  = rst_bytes[i];
      step_cycle();
    end
    tx_valid = 1'b0;
    bad_cnt = 0;
    while (!(m_active && m_byte == 8'hC3 && (edge_n - m_start) == 4 * BIT_CYCLES + 6) && bad_cnt < 300) begin
      step_cycle();
      bad_cnt++;
    end
    check("rst_reach_bit3", bad_cnt < 300, 1);
    check("rst_queued", mq.size(), 2);
    #2 reset = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_ready", tx_ready, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_overflow", tx_overflow, 0);
    mq.delete();
    exp_q.delete();
    m_active = 1'b0;
    repeat (3) step_cycle();
    reset = 1'b1;
    frames_before = frames_seen;
    bad_cnt = 0;
    repeat (400) begin
      step_cycle();
      if (s_tx !== 1'b1 || s_busy !== 1'b0) bad_cnt++;
    end
    check("post_rst_frames", frames_seen, frames_before);
    check("post_rst_line", bad_cnt, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter for the host link, the transmit counterpart of the 8x-oversampled receive path. Accepts bytes from the coprocessor result logic through a valid/ready write port. Buffers them in a small FIFO and serialises each as 8N1 frames, LSB first, on the tx line. It generates its own 1x bit-timing internally, so no external tick generator is needed.

Parameters:
CLK_FREQUENCY, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE (integer division, must be >= 2)
FIFO_DEPTH, 4, number of byte entries in the buffer; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
tx_data  input  8  byte to transmit
tx_valid  input  1  write request; sampled on rising edge of clk
tx_ready  output  1  FIFO not full; a write is accepted when tx_valid & tx_ready
tx  output  1  serial line, registered, idle high
tx_busy  output  1  1 while any frame is in progress or the FIFO is non-empty
tx_overflow  output  1  one-cycle pulse when tx_valid=1 and tx_ready=0 (byte dropped)

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, tx_ready=1, tx_busy=0, tx_overflow=0.
  - FIFO count=0, read/write pointers=0, state=IDLE, bit counter=0.
  - Reset mid-frame aborts the frame immediately: tx goes high with no clock edge. The partial byte and all buffered bytes are discarded. There is no resume after reset release.
- FIFO:
  - Count register ranges 0..FIFO_DEPTH, with wrap-around pointers. tx_ready = (count != FIFO_DEPTH), derived from registered count.
  - A push while full is rejected even if a pop happens in the same cycle. It raises tx_overflow for exactly that cycle.
  - A simultaneous push and pop leaves count unchanged.
- Baud timing:
  - A cycle counter runs 0..BIT_CYCLES-1 only while state != IDLE.
  - The counter is cleared when a frame starts, so each bit is held exactly BIT_CYCLES clocks.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: if count>0 at an edge, pop the head into an 8-bit shift register, set tx<=0, and go to START. Otherwise hold tx=1.
  - START: after BIT_CYCLES cycles, tx<=shift[0] and go to DATA with bit index 0.
  - DATA: every BIT_CYCLES cycles, shift right and drive the next bit. After bit 7 has been held BIT_CYCLES cycles, tx<=1 and go to STOP.
  - STOP: after BIT_CYCLES cycles, check the FIFO.
    - If count>0: pop the next byte, tx<=0, go to START. Frames are back-to-back with no idle gap.
    - Otherwise: go to IDLE with tx=1.
- Timing:
  - A frame is exactly 10*BIT_CYCLES clocks.
  - Latency: a write accepted at edge E0 into an idle, empty block drives tx low at edge E0+1.
- tx_busy = (state != IDLE) | (count != 0), combinational from registers.
- tx_data changes after acceptance do not affect the byte already stored.

Test Plan:
(Bench uses CLK_FREQUENCY=1_600_000, BAUD_RATE=100_000, so BIT_CYCLES=16.)
- Single byte: after reset release, write 0xA5 once.
  - tx falls one edge later and stays low 16 cycles.
  - Data bits are 1,0,1,0,0,1,0,1, each 16 cycles, followed by a 16-cycle high stop bit.
  - tx_busy is high for 161 cycles, then 0.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles.
  - Three frames appear with no idle gap: 480 cycles from the first falling edge to the final stop-bit end.
  - A bench-side UART model decodes 0x00, 0xFF, 0x55 in order.
- Full/overflow: hold tx_valid for 6 consecutive cycles (bytes 0x10..0x15) while idle.
  - Timeline: 0x10 is popped after one cycle, then 4 more fill the FIFO, so tx_ready=0 on the 6th cycle.
  - 0x15 is dropped and tx_overflow pulses for exactly 1 cycle.
  - Output sequence is 0x10..0x14.
- Push while full with simultaneous pop: with the FIFO full, write in the exact cycle the STOP state pops.
  - The write is rejected and tx_overflow=1.
  - Count goes from FIFO_DEPTH to FIFO_DEPTH-1.
- Reset mid-frame: assert reset=0 during the DATA bit 3 of 0xC3 with 2 bytes queued.
  - tx=1 asynchronously, tx_ready=1, tx_busy=0.
  - After release, no further frames are emitted.
- Idle line: with no writes for 1000 cycles after reset, tx stays 1, tx_busy=0, and tx_overflow=0 throughout.
